// File: rtl/position_table_if.sv
// Bus between the Nios PIO / renderer side and the position table receiver.
// The producer drives the PIO word and read index; the receiver returns table reads and status.
interface position_table_if;
  logic [31:0] position_word;
  logic        vblank_start;
  logic [3:0]  rd_idx;
  logic [9:0]  rd_x;
  logic [8:0]  rd_y;
  logic [6:0]  rd_attr;
  logic        refresh_image;
  logic        overrun;
  logic        bad_idx;
  logic [15:0] frame_count;

  modport master (
    output position_word, vblank_start, rd_idx,
    input  rd_x, rd_y, rd_attr, refresh_image, overrun, bad_idx, frame_count
  );

  modport slave (
    input  position_word, vblank_start, rd_idx,
    output rd_x, rd_y, rd_attr, refresh_image, overrun, bad_idx, frame_count
  );
endinterface

// File: rtl/position_table_rx.sv
// Decodes toggle-qualified PIO words into a shadow sprite table and copies it to the
// active table during vertical blank, so the renderer only ever sees complete frames.
module position_table_rx #(
  parameter int N_SPRITES = 16
) (
  input logic             clk,
  input logic             reset_n,
  position_table_if.slave bus
);

  localparam logic [1:0] ST_READY   = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [1:0] ST_SWAP    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        last_toggle_q;
  logic        refresh_q, refresh_d;
  logic        overrun_q, overrun_d;
  logic        bad_idx_q, bad_idx_d;
  logic [15:0] frame_q, frame_d;

  logic [9:0] sh_x_q   [N_SPRITES];
  logic [8:0] sh_y_q   [N_SPRITES];
  logic [6:0] sh_attr_q[N_SPRITES];
  logic [9:0] act_x_q   [N_SPRITES];
  logic [8:0] act_y_q   [N_SPRITES];
  logic [6:0] act_attr_q[N_SPRITES];

  logic [9:0] rd_x_q, rd_x_d;
  logic [8:0] rd_y_q, rd_y_d;
  logic [6:0] rd_attr_q, rd_attr_d;

  logic       new_word;
  logic       accept;
  logic       w_commit;
  logic       idx_ok;
  logic [3:0] w_idx;
  logic [9:0] w_x;
  logic [6:0] w_attr;
  logic [8:0] w_y;

  // Word fields and acceptance: a toggle edge is consumed in every state, but only
  // READY/FILL take the payload; anything arriving while a swap is outstanding is an overrun.
  assign new_word = bus.position_word[31] != last_toggle_q;
  assign w_commit = bus.position_word[30];
  assign w_idx    = bus.position_word[29:26];
  assign w_x      = bus.position_word[25:16];
  assign w_attr   = bus.position_word[15:9];
  assign w_y      = bus.position_word[8:0];
  assign idx_ok   = int'(w_idx) < N_SPRITES;
  assign accept   = new_word && (state_q == ST_READY || state_q == ST_FILL);

  always_comb begin
    state_d   = state_q;
    refresh_d = refresh_q;
    overrun_d = overrun_q;
    bad_idx_d = bad_idx_q;
    frame_d   = frame_q;
    case (state_q)
      ST_READY, ST_FILL: begin
        if (accept) begin
          state_d   = w_commit ? ST_PENDING : ST_FILL;
          refresh_d = 1'b0;
          if (!idx_ok) bad_idx_d = 1'b1;
        end
      end
      ST_PENDING: begin
        if (bus.vblank_start) state_d = ST_SWAP;
        if (new_word) overrun_d = 1'b1;
      end
      ST_SWAP: begin
        state_d   = ST_READY;
        refresh_d = 1'b1;
        frame_d   = frame_q + 16'd1;
        if (new_word) overrun_d = 1'b1;
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_READY;
      last_toggle_q <= 1'b0;
      refresh_q     <= 1'b1;
      overrun_q     <= 1'b0;
      bad_idx_q     <= 1'b0;
      frame_q       <= 16'd0;
    end else begin
      state_q       <= state_d;
      last_toggle_q <= bus.position_word[31];
      refresh_q     <= refresh_d;
      overrun_q     <= overrun_d;
      bad_idx_q     <= bad_idx_d;
      frame_q       <= frame_d;
    end
  end

  // Shadow takes accepted words; active copies the whole shadow in the SWAP cycle.
  // An out-of-range index matches no entry, so it is dropped without extra gating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sh_x_q[i]     <= '0;
        sh_y_q[i]     <= '0;
        sh_attr_q[i]  <= '0;
        act_x_q[i]    <= '0;
        act_y_q[i]    <= '0;
        act_attr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (accept && w_idx == 4'(i)) begin
          sh_x_q[i]    <= w_x;
          sh_y_q[i]    <= w_y;
          sh_attr_q[i] <= w_attr;
        end
        if (state_q == ST_SWAP) begin
          act_x_q[i]    <= sh_x_q[i];
          act_y_q[i]    <= sh_y_q[i];
          act_attr_q[i] <= sh_attr_q[i];
        end
      end
    end
  end

  always_comb begin
    rd_x_d    = '0;
    rd_y_d    = '0;
    rd_attr_d = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (bus.rd_idx == 4'(i)) begin
        rd_x_d    = act_x_q[i];
        rd_y_d    = act_y_q[i];
        rd_attr_d = act_attr_q[i];
      end
    end
  end

  // Registered read port: a read issued in the SWAP cycle still sees the old frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      rd_attr_q <= '0;
    end else begin
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      rd_attr_q <= rd_attr_d;
    end
  end

  assign bus.rd_x          = rd_x_q;
  assign bus.rd_y          = rd_y_q;
  assign bus.rd_attr       = rd_attr_q;
  assign bus.refresh_image = refresh_q;
  assign bus.overrun       = overrun_q;
  assign bus.bad_idx       = bad_idx_q;
  assign bus.frame_count   = frame_q;

endmodule

// File: tb/tb_position_table_rx.sv
// Scoreboard bench: stimulus pushes expected output values, a negedge monitor pops and compares.
module tb_position_table_rx;

  localparam int SEL_X = 0, SEL_Y = 1, SEL_ATTR = 2, SEL_REF = 3,
                 SEL_OVR = 4, SEL_BAD = 5, SEL_FRM = 6;

  typedef struct {
    int          dut;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pw [2];
  logic        vb [2];
  logic [3:0]  ri [2];
  logic        tog [2];
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  position_table_if ifa ();
  position_table_if ifb ();

  assign ifa.position_word = pw[0];
  assign ifa.vblank_start  = vb[0];
  assign ifa.rd_idx        = ri[0];
  assign ifb.position_word = pw[1];
  assign ifb.vblank_start  = vb[1];
  assign ifb.rd_idx        = ri[1];

  position_table_rx #(.N_SPRITES(16)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  position_table_rx #(.N_SPRITES(8))  dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  function automatic logic [31:0] get(input int d, input int sel);
    logic [31:0] v;
    v = 32'hDEAD_BEEF;
    if (d == 0) begin
      case (sel)
        SEL_X:    v = 32'(ifa.rd_x);
        SEL_Y:    v = 32'(ifa.rd_y);
        SEL_ATTR: v = 32'(ifa.rd_attr);
        SEL_REF:  v = 32'(ifa.refresh_image);
        SEL_OVR:  v = 32'(ifa.overrun);
        SEL_BAD:  v = 32'(ifa.bad_idx);
        SEL_FRM:  v = 32'(ifa.frame_count);
        default:  v = 32'hDEAD_BEEF;
      endcase
    end else begin
      case (sel)
        SEL_X:    v = 32'(ifb.rd_x);
        SEL_Y:    v = 32'(ifb.rd_y);
        SEL_ATTR: v = 32'(ifb.rd_attr);
        SEL_REF:  v = 32'(ifb.refresh_image);
        SEL_OVR:  v = 32'(ifb.overrun);
        SEL_BAD:  v = 32'(ifb.bad_idx);
        SEL_FRM:  v = 32'(ifb.frame_count);
        default:  v = 32'hDEAD_BEEF;
      endcase
    end
    return v;
  endfunction

  // Monitor: everything queued in a cycle is compared at that cycle's falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = get(e.dut, e.sel);
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s (dut %0d): got %0d, expected %0d", e.name, e.dut, act, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int d, input int sel, input int exp, input string name);
    exp_t e;
    e.dut  = d;
    e.sel  = sel;
    e.exp  = 32'(exp);
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic send(input int d, input bit c, input int idx, input int x,
                      input int attr, input int y);
    tog[d] = ~tog[d];
    pw[d]  = {tog[d], c, 4'(idx), 10'(x), 7'(attr), 9'(y)};
    tick(1);
  endtask

  task automatic pulse(input int d);
    vb[d] = 1'b1;
    tick(1);
    vb[d] = 1'b0;
  endtask

  task automatic rd(input int d, input int idx, input int ex, input int ey,
                    input int ea, input string name);
    ri[d] = 4'(idx);
    tick(1);
    chk(d, SEL_X, ex, {name, ".x"});
    chk(d, SEL_Y, ey, {name, ".y"});
    chk(d, SEL_ATTR, ea, {name, ".attr"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      pw[d] = '0; vb[d] = 1'b0; ri[d] = '0; tog[d] = 1'b0;
    end
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // 1: reset state
    chk(0, SEL_REF, 1, "rst.refresh");
    chk(0, SEL_FRM, 0, "rst.frame");
    chk(0, SEL_OVR, 0, "rst.overrun");
    chk(0, SEL_BAD, 0, "rst.bad_idx");
    for (int i = 0; i < 16; i++) rd(0, i, 0, 0, 0, "rst.rd");

    // 2: fill, commit, swap on vblank
    send(0, 1'b0, 3, 320, 5, 240);
    chk(0, SEL_REF, 0, "fill.refresh");
    send(0, 1'b1, 0, 10, 0, 20);
    ri[0] = 4'd3;
    tick(3);
    chk(0, SEL_FRM, 0, "pending.frame");
    chk(0, SEL_REF, 0, "pending.refresh");
    chk(0, SEL_X, 0, "pending.rd3.x");
    pulse(0);
    tick(1);
    chk(0, SEL_X, 0, "swapcycle.rd3.x");
    tick(1);
    chk(0, SEL_X, 320, "swap+2.rd3.x");
    chk(0, SEL_Y, 240, "swap+2.rd3.y");
    chk(0, SEL_ATTR, 5, "swap+2.rd3.attr");
    chk(0, SEL_REF, 1, "swap.refresh");
    chk(0, SEL_FRM, 1, "swap.frame");
    rd(0, 0, 10, 20, 0, "swap.rd0");

    // 3: toggle held constant -> ignored
    pw[0] = {tog[0], 1'b1, 4'd3, 10'd999, 7'd9, 9'd77};
    tick(3);
    chk(0, SEL_REF, 1, "hold.refresh");
    pulse(0);
    tick(3);
    chk(0, SEL_FRM, 1, "hold.frame");
    rd(0, 3, 320, 240, 5, "hold.rd3");

    // 4: overrun while pending
    send(0, 1'b0, 5, 55, 7, 66);
    send(0, 1'b1, 1, 11, 1, 12);
    chk(0, SEL_OVR, 0, "ovr.before");
    send(0, 1'b0, 5, 500, 2, 400);
    chk(0, SEL_OVR, 1, "ovr.after");
    pulse(0);
    tick(3);
    chk(0, SEL_FRM, 2, "ovr.frame");
    rd(0, 5, 55, 66, 7, "ovr.rd5");
    rd(0, 1, 11, 12, 1, "ovr.rd1");
    rd(0, 3, 320, 240, 5, "carry.rd3");

    // 5: commit coincident with vblank -> swap only on the next pulse
    vb[0] = 1'b1;
    send(0, 1'b1, 2, 22, 3, 33);
    vb[0] = 1'b0;
    tick(3);
    chk(0, SEL_FRM, 2, "coinc.frame");
    chk(0, SEL_REF, 0, "coinc.refresh");
    rd(0, 2, 0, 0, 0, "coinc.rd2");
    pulse(0);
    tick(3);
    chk(0, SEL_FRM, 3, "coinc.frame2");
    chk(0, SEL_REF, 1, "coinc.refresh2");
    rd(0, 2, 22, 33, 3, "coinc.rd2b");

    // 6: out-of-range index on the 8-entry instance
    chk(1, SEL_BAD, 0, "bad.before");
    send(1, 1'b0, 4, 44, 6, 45);
    send(1, 1'b1, 15, 100, 1, 101);
    chk(1, SEL_BAD, 1, "bad.after");
    chk(1, SEL_REF, 0, "bad.pending");
    pulse(1);
    tick(3);
    chk(1, SEL_FRM, 1, "bad.frame");
    chk(1, SEL_OVR, 0, "bad.overrun");
    rd(1, 15, 0, 0, 0, "bad.rd15");
    rd(1, 4, 44, 45, 6, "bad.rd4");
    rd(1, 7, 0, 0, 0, "bad.rd7");

    tick(2);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: got %0d pending entries, expected 0", sb.size());
    end
    if (n_chk < 100) begin
      n_fail++;
      $display("FAIL coverage: got %0d comparisons, expected at least 100", n_chk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    if (n_fail == 0) $display("PASS");
    else $display("FAIL: %0d mismatches", n_fail);
    $finish;
  end

endmodule
